// File: rtl/wav_monitor_pkg.sv
// wav_monitor shared types, defaults and helpers.
// Threshold helpers saturate MID+/-HYST into 0..255.
package wav_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    MEASURE
  } state_t;

  localparam int unsigned PERIOD_W_DEF = 24;
  localparam int unsigned TIMEOUT_DEF = 10_000_000;
  localparam logic [7:0] MID_DEF = 8'd128;
  localparam logic [7:0] HYST_DEF = 8'd8;

  function automatic logic [7:0] th_lo(
    input logic [7:0] m,
    input logic [7:0] h
  );
    logic [8:0] d;
    d = {1'b0, m} - {1'b0, h};
    return d[8] ? 8'd0 : d[7:0];
  endfunction

  function automatic logic [7:0] th_hi(
    input logic [7:0] m,
    input logic [7:0] h
  );
    logic [8:0] s;
    s = {1'b0, m} + {1'b0, h};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] min8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wavmon_xdet.sv
// Rising midscale crossing detector with armed "below" flag.
// WAVMON_HYST_EN selects the MID-HYST / MID+HYST hysteresis band.
module wavmon_xdet
  import wav_monitor_pkg::*;
#(
  parameter logic [7:0] MID  = MID_DEF,
  parameter logic [7:0] HYST = HYST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       samp_stb,
  input  logic [7:0] samp,
  input  logic       clear,
  output logic       xing
);

`ifdef WAVMON_HYST_EN
  localparam logic HYST_ON = 1'b1;
`else
  localparam logic HYST_ON = 1'b0;
`endif

  localparam logic [7:0] BAND = HYST_ON ? HYST : 8'd0;
  localparam logic [7:0] LO = th_lo(MID, BAND);
  localparam logic [7:0] HI = th_hi(MID, BAND);

  logic below;
  logic low;
  logic high;

  always_comb begin
    low  = HYST_ON ? (samp <= LO) : (samp < MID);
    high = (samp >= HI);
  end

  assign xing = samp_stb & below & high & ~clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      below <= 1'b0;
    end else if (samp_stb) begin
      if (xing) begin
        below <= 1'b0;
      end else if (low) begin
        below <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wav_monitor.sv
// Waveform period / min / max monitor on rising midscale crossings.
// Define WAVMON_HYST_EN to enable crossing hysteresis.
module wav_monitor
  import wav_monitor_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter logic [PERIOD_W-1:0] TIMEOUT = PERIOD_W'(TIMEOUT_DEF),
  parameter logic [7:0] MID  = MID_DEF,
  parameter logic [7:0] HYST = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                samp_stb,
  input  logic [7:0]          samp,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          vmax,
  output logic [7:0]          vmin,
  output logic                meas_valid,
  output logic                timeout,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_LAST = TIMEOUT - CNT_ONE;

  state_t state;
  state_t state_nxt;

  logic [PERIOD_W-1:0] cnt;
  logic [7:0] acc_min;
  logic [7:0] acc_max;
  logic       clear;
  logic       xing;
  logic       seek_hit;
  logic       meas_hit;
  logic       tmo_hit;
  logic       meas_run;

  // Detector stays disarmed while idle so a new run starts clean.
  assign clear = ~en | (state == IDLE);

  wavmon_xdet #(
    .MID  (MID),
    .HYST (HYST)
  ) u_xdet (
    .clk      (clk),
    .rst      (rst),
    .samp_stb (samp_stb),
    .samp     (samp),
    .clear    (clear),
    .xing     (xing)
  );

  assign meas_run = (state == MEASURE) & en;
  assign seek_hit = (state == SEEK) & xing;
  assign meas_hit = (state == MEASURE) & xing;
  assign tmo_hit  = meas_run & ~xing & (cnt == CNT_LAST);
  assign busy     = (state == MEASURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = SEEK;
      SEEK:    if (seek_hit) state_nxt = MEASURE;
      MEASURE: if (tmo_hit) state_nxt = SEEK;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc_min    <= '0;
      acc_max    <= '0;
      period     <= '0;
      vmin       <= '0;
      vmax       <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (seek_hit) begin
        cnt     <= '0;
        acc_min <= samp;
        acc_max <= samp;
      end else if (meas_hit) begin
        period     <= cnt + CNT_ONE;
        vmin       <= min8(acc_min, samp);
        vmax       <= max8(acc_max, samp);
        meas_valid <= 1'b1;
        timeout    <= 1'b0;
        cnt        <= '0;
        acc_min    <= samp;
        acc_max    <= samp;
      end else if (meas_run) begin
        cnt <= cnt + CNT_ONE;
        if (samp_stb) begin
          acc_min <= min8(acc_min, samp);
          acc_max <= max8(acc_max, samp);
        end
        if (tmo_hit) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wav_monitor.sv
// Bench for wav_monitor: two instances (short and long abort limit)
// checked every cycle against a crossing-log reference model.
module tb_wav_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic samp_stb = 1'b0;
  logic [7:0] samp = 8'd0;

  logic [23:0] per [2];
  logic [7:0]  vmx [2];
  logic [7:0]  vmn [2];
  logic        mv  [2];
  logic        to  [2];
  logic        bsy [2];

  always #5 clk = ~clk;

  wav_monitor #(.PERIOD_W(24), .TIMEOUT(24'd1000)) dut_a (
    .clk(clk), .rst(rst), .en(en), .samp_stb(samp_stb), .samp(samp),
    .period(per[0]), .vmax(vmx[0]), .vmin(vmn[0]),
    .meas_valid(mv[0]), .timeout(to[0]), .busy(bsy[0])
  );

  wav_monitor #(.PERIOD_W(24), .TIMEOUT(24'd4000)) dut_b (
    .clk(clk), .rst(rst), .en(en), .samp_stb(samp_stb), .samp(samp),
    .period(per[1]), .vmax(vmx[1]), .vmin(vmn[1]),
    .meas_valid(mv[1]), .timeout(to[1]), .busy(bsy[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nmv [2];

  // reference model: 0 idle, 1 seek, 2 measure
  int m_mode [2];
  bit m_below [2];
  int m_tl [2];
  int m_per [2];
  int m_min [2];
  int m_max [2];
  bit m_mv [2];
  bit m_to [2];
  int hs [$];
  int hc [$];

  function automatic int tmo(int i);
    return (i == 0) ? 1000 : 4000;
  endfunction

  function automatic bit is_lo(int s);
`ifdef WAVMON_HYST_EN
    return s <= 120;
`else
    return s < 128;
`endif
  endfunction

  function automatic bit is_hi(int s);
`ifdef WAVMON_HYST_EN
    return s >= 136;
`else
    return s >= 128;
`endif
  endfunction

  task automatic chk(string nm, int i, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s dut%0d cyc %0d got %0d want %0d",
                 nm, i, cyc, act, exp);
    end
  endtask

  task automatic mstep(int i, bit r, bit e, bit st, int s);
    bit x;
    m_mv[i] = 1'b0;
    if (r) begin
      m_mode[i] = 0; m_below[i] = 0; m_per[i] = 0;
      m_min[i] = 0; m_max[i] = 0; m_to[i] = 0;
    end else if (!e) begin
      m_mode[i] = 0; m_below[i] = 0;
    end else if (m_mode[i] == 0) begin
      m_mode[i] = 1;
    end else begin
      x = st && m_below[i] && is_hi(s);
      if (st) begin
        if (x) m_below[i] = 0;
        else if (is_lo(s)) m_below[i] = 1;
      end
      if (m_mode[i] == 1) begin
        if (x) begin m_mode[i] = 2; m_tl[i] = cyc; end
      end else if (x) begin
        int lo, hi;
        lo = 255; hi = 0;
        for (int k = hs.size() - 1; k >= 0 && hc[k] >= m_tl[i]; k--) begin
          if (hs[k] < lo) lo = hs[k];
          if (hs[k] > hi) hi = hs[k];
        end
        m_per[i] = cyc - m_tl[i];
        m_min[i] = lo; m_max[i] = hi;
        m_mv[i] = 1; m_to[i] = 0; m_tl[i] = cyc;
      end else if (cyc - m_tl[i] == tmo(i)) begin
        m_to[i] = 1; m_mode[i] = 1;
      end
    end
  endtask

  task automatic tick(bit r, bit e, bit st, int s);
    rst = r; en = e; samp_stb = st; samp = 8'(s);
    @(posedge clk);
    if (st) begin hs.push_back(s); hc.push_back(cyc); end
    mstep(0, r, e, st, s);
    mstep(1, r, e, st, s);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("period", i, int'(per[i]), m_per[i]);
      chk("vmin", i, int'(vmn[i]), m_min[i]);
      chk("vmax", i, int'(vmx[i]), m_max[i]);
      chk("meas_valid", i, int'(mv[i]), int'(m_mv[i]));
      chk("timeout", i, int'(to[i]), int'(m_to[i]));
      chk("busy", i, int'(bsy[i]), int'(m_mode[i] == 2));
      if (mv[i]) nmv[i]++;
    end
    cyc++;
  endtask

  task automatic half_sq(int v, int n);
    for (int k = 0; k < n; k++) tick(0, 1, 1, v);
  endtask

  typedef struct {
    bit r, e, st;
    int s;
    bit xmv;
    int xper, xmin, xmax;
    bit xto, xbusy;
  } vec_t;

  vec_t tbl [10];

  int base, c0, tk;
  bit seen;

  initial begin
    nmv[0] = 0; nmv[1] = 0;
    tbl[0] = '{1, 0, 0, 0,   0, 0, 0, 0,   0, 0};
    tbl[1] = '{0, 1, 1, 0,   0, 0, 0, 0,   0, 0};
    tbl[2] = '{0, 1, 1, 0,   0, 0, 0, 0,   0, 0};
    tbl[3] = '{0, 1, 1, 255, 0, 0, 0, 0,   0, 1};
    tbl[4] = '{0, 1, 1, 0,   0, 0, 0, 0,   0, 1};
    tbl[5] = '{0, 1, 0, 100, 0, 0, 0, 0,   0, 1};
    tbl[6] = '{0, 1, 1, 255, 1, 3, 0, 255, 0, 1};
    tbl[7] = '{0, 1, 1, 255, 0, 3, 0, 255, 0, 1};
    tbl[8] = '{0, 0, 1, 0,   0, 3, 0, 255, 0, 0};
    tbl[9] = '{1, 1, 1, 0,   0, 0, 0, 0,   0, 0};

    for (int v = 0; v < 10; v++) begin
      tick(tbl[v].r, tbl[v].e, tbl[v].st, tbl[v].s);
      chk("tbl_mv", v, int'(mv[0]), int'(tbl[v].xmv));
      chk("tbl_period", v, int'(per[0]), tbl[v].xper);
      chk("tbl_vmin", v, int'(vmn[0]), tbl[v].xmin);
      chk("tbl_vmax", v, int'(vmx[0]), tbl[v].xmax);
      chk("tbl_timeout", v, int'(to[0]), int'(tbl[v].xto));
      chk("tbl_busy", v, int'(bsy[0]), int'(tbl[v].xbusy));
    end

    // square 0/255, 50 strobes each
    tick(1, 0, 0, 0);
    base = nmv[0];
    for (int p = 0; p < 4; p++) begin
      half_sq(0, 50);
      half_sq(255, 50);
    end
    chk("sq_count", 0, nmv[0] - base, 3);
    chk("sq_period", 0, int'(per[0]), 100);
    chk("sq_vmin", 0, int'(vmn[0]), 0);
    chk("sq_vmax", 0, int'(vmx[0]), 255);

    // enable drop mid-measure, then re-arm
    tick(0, 0, 1, 0);
    chk("endrop_busy", 0, int'(bsy[0]), 0);
    chk("endrop_period", 0, int'(per[0]), 100);
    base = nmv[0];
    half_sq(0, 50);
    half_sq(255, 50);
    chk("reen_one_xing", 0, nmv[0] - base, 0);
    half_sq(0, 50);
    half_sq(255, 50);
    chk("reen_two_xing", 0, nmv[0] - base, 1);
    chk("reen_period", 0, int'(per[0]), 100);

    // reset in the middle of a measurement
    half_sq(0, 20);
    tick(1, 1, 1, 0);
    chk("rst_period", 0, int'(per[0]), 0);
    chk("rst_vmax", 0, int'(vmx[0]), 0);
    chk("rst_busy", 0, int'(bsy[0]), 0);

    // alternating 126 / 130
    tick(1, 0, 0, 0);
    base = nmv[0];
    for (int k = 0; k < 40; k++) tick(0, 1, 1, (k % 2 == 0) ? 126 : 130);
`ifdef WAVMON_HYST_EN
    chk("alt_none", 0, nmv[0] - base, 0);
`else
    chk("alt_count", 0, int'(nmv[0] - base >= 10), 1);
    chk("alt_period", 0, int'(per[0]), 2);
    chk("alt_vmin", 0, int'(vmn[0]), 126);
    chk("alt_vmax", 0, int'(vmx[0]), 130);
`endif

    // abort after one crossing then a flat input
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    c0 = cyc;
    tick(0, 1, 1, 255);
    base = nmv[0];
    seen = 0;
    tk = -1;
    for (int k = 0; k < 1100; k++) begin
      tick(0, 1, 1, 200);
      if (!seen && to[0]) begin seen = 1; tk = cyc - 1 - c0; end
    end
    chk("tmo_delay", 0, tk, 1000);
    chk("tmo_busy", 0, int'(bsy[0]), 0);
    chk("tmo_no_mv", 0, nmv[0] - base, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 255);
    half_sq(0, 5);
    tick(0, 1, 1, 255);
    chk("tmo_mv", 0, int'(mv[0]), 1);
    chk("tmo_clear", 0, int'(to[0]), 0);
    chk("tmo_period", 0, int'(per[0]), 6);

    // triangle, strobe every 4th cycle, long-limit instance
    tick(1, 0, 0, 0);
    for (int n = 0; n < 1300; n++) begin
      int m, v;
      m = n % 510;
      v = (m <= 255) ? m : 510 - m;
      tick(0, 1, 1, v);
      for (int j = 0; j < 3; j++) tick(0, 1, 0, v);
    end
    chk("tri_period", 1, int'(per[1]), 2040);
    chk("tri_vmin", 1, int'(vmn[1]), 0);
    chk("tri_vmax", 1, int'(vmx[1]), 255);

    // random traffic against the model
    tick(1, 0, 0, 0);
    begin
      bit e;
      e = 1;
      for (int k = 0; k < 4000; k++) begin
        int s;
        if ($urandom_range(0, 299) == 0) e = ~e;
        if ($urandom_range(0, 2) == 0) s = $urandom_range(118, 138);
        else s = $urandom_range(0, 255);
        tick($urandom_range(0, 499) == 0, e, $urandom_range(0, 1) == 1, s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
